game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level game sequencer for the snake game. It runs the IDLE → PLAY → game-over flow from frame ticks, start-button presses and collision/food events. It drives the snake move strobe, the score, the `game_over` level and a 2-bit colour mode for the pixel colour stage. All outputs are registered; everything sits in the pixel-clock domain alongside the VGA timing and colour logic.

## Interface
- `MOVE_DIV`, default 8: frames per snake move at game start (≥2).
- `MIN_DIV`, default 2: fastest allowed frames-per-move (1 ≤ MIN_DIV ≤ MOVE_DIV).
- `SPEEDUP_EVERY`, default 4: food items eaten per one-step speed-up.
- `FLASH_FRAMES`, default 32: length of the game-over flash phase in frames.
- `FLASH_HALF`, default 8: frames per flash half-period (RED/BLACK toggle).
- `SCORE_W`, default 8: score width.
- `clk` in 1: pixel clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `frame_tick` in 1: one-cycle pulse at the start of each frame.
- `start_btn` in 1: synchronised, debounced level; only rising edges act.
- `collision` in 1: one-cycle pulse when the head hits a boundary or the body.
- `food_eaten` in 1: one-cycle pulse when the head reaches the food.
- `move_en` out 1: one-cycle strobe that advances the snake.
- `game_over` out 1: level, high in OVER_FLASH and OVER_HOLD.
- `color_mode` out 2: colour mode for the colour stage. 00 NORMAL (bound/snake/food priority), 01 BLACK, 10 RED.
- `score` out SCORE_W: food count since the last start, saturating.

## Operation
- Reset values:
  - state IDLE
  - `move_en`=0, `game_over`=0, `color_mode`=00, `score`=0
  - internal counters 0
  - `div` = MOVE_DIV
  - `start_btn` history register = 1, so a button held through reset does not start a game.
- Start edge: registered `start_btn` history; `start_rise = start_btn & ~prev`.
- IDLE:
  - `color_mode`=00, `move_en` never asserted.
  - `start_rise` → PLAY with score=0, `div`=MOVE_DIV, frame_cnt=0, food_cnt=0.
- PLAY:
  - Frame counting: each `frame_tick` increments frame_cnt. When a tick arrives with frame_cnt == `div`−1, frame_cnt wraps to 0 and `move_en` pulses on the next cycle.
  - Food: `food_eaten` increments `score`, saturating at 2^SCORE_W−1. It also increments food_cnt. When food_cnt reaches SPEEDUP_EVERY it returns to 0, and `div` decrements if `div` > MIN_DIV.
  - If a decrement makes frame_cnt ≥ new `div`, frame_cnt clears to 0.
  - Collision: `collision` → OVER_FLASH with flash_cnt=0 and `color_mode`=10.
- Simultaneous events in PLAY:
  - `collision` beats `food_eaten`: score is not incremented.
  - `collision` on a qualifying `frame_tick`: no `move_en`.
  - `start_rise` in PLAY is ignored.
- OVER_FLASH:
  - `game_over`=1.
  - Each `frame_tick` increments flash_cnt. `color_mode` toggles between 10 and 01 every FLASH_HALF ticks.
  - After the FLASH_FRAMES-th tick → OVER_HOLD.
  - `start_rise`, `collision` and `food_eaten` are ignored.
- OVER_HOLD:
  - `game_over`=1, `color_mode`=01, `score` holds.
  - `start_rise` → PLAY with the same initialisation as from IDLE. `game_over` drops with the state change.
- Reset mid-operation: immediate return to the reset values from any state.

## Timing
- All transitions and outputs update on the clock edge after the causing input cycle: 1-cycle latency.
- `move_en` is exactly one cycle wide, with at most one pulse per `frame_tick`.
- First `move_en` after start: the cycle after the MOVE_DIV-th `frame_tick` following entry to PLAY.
- A `frame_tick` in the same cycle as `start_rise` is not counted.
- `score` is visible the cycle after `food_eaten`.
- `game_over` rises the cycle after `collision`.

## Structure
- Shared package `game_pkg`:
  - state enum: IDLE, PLAY, OVER_FLASH, OVER_HOLD
  - colour-mode constants: CM_NORMAL=2'b00, CM_BLACK=2'b01, CM_RED=2'b10
  - The colour stage imports the same constants.
- Sub-module `frame_div`: programmable frame divider with a `div` input, `frame_tick` input, synchronous clear, and registered `move_en` output. It holds frame_cnt and the clamp-on-shrink rule.
- The FSM, score, food_cnt and flash logic stay in `game_ctrl`.

## Test plan
- Reset with `start_btn` held high, then release and press again → no start on release; PLAY the cycle after the press rising edge, `score`=0.
- PLAY with default params and 24 frame ticks → `move_en` pulses exactly 3 times, each the cycle after ticks 8, 16 and 24.
- 8 `food_eaten` pulses with frame ticks running → `score`=8. `div` goes 8→7 after the 4th food and 7→6 after the 8th; move spacing shrinks accordingly. Repeat to confirm `div` floors at 2.
- `collision` and `food_eaten` in the same cycle → next cycle OVER_FLASH, `game_over`=1, `color_mode`=10, score unchanged. `color_mode` toggles every 8 ticks; OVER_HOLD with `color_mode`=01 after 32 ticks. `start_btn` pressed during the flash is ignored.
- `start_btn` pressed in OVER_HOLD → PLAY next cycle, `score`=0, `game_over`=0, `div`=8.
- Assert `rst_n` low mid-PLAY with `move_en` due → outputs go to reset values immediately (asynchronously); no stray `move_en` after release.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the snake game sequencer and the pixel colour stage.
//   - game_state_e / ST_* : sequencer states (enum for readability, localparam
//                           constants for the legacy-style state register)
//   - CM_*                : colour-mode codes driven to the colour stage
//   - flashToggle()       : next colour while flashing after a game over
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY       = 2'd1,
    OVER_FLASH = 2'd2,
    OVER_HOLD  = 2'd3
  } game_state_e;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PLAY       = 2'd1;
  localparam logic [1:0] ST_OVER_FLASH = 2'd2;
  localparam logic [1:0] ST_OVER_HOLD  = 2'd3;

  typedef logic [1:0] color_mode_t;

  localparam color_mode_t CM_NORMAL = 2'b00;
  localparam color_mode_t CM_BLACK  = 2'b01;
  localparam color_mode_t CM_RED    = 2'b10;

  // Game-over flash alternates red and black; anything else restarts on red.
  function automatic color_mode_t flashToggle(input color_mode_t cm);
    return (cm == CM_RED) ? CM_BLACK : CM_RED;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_if
// Event/status bundle between the game sequencer and the rest of the game.
//   frame_tick  : one-cycle pulse per frame             (to sequencer)
//   start_btn   : debounced start button level          (to sequencer)
//   collision   : one-cycle head collision pulse        (to sequencer)
//   food_eaten  : one-cycle food pulse                  (to sequencer)
//   move_en     : one-cycle snake advance strobe        (from sequencer)
//   game_over   : high while the game-over screen shows (from sequencer)
//   color_mode  : colour-stage mode, see game_pkg CM_*  (from sequencer)
//   score       : saturating food count                 (from sequencer)
// master = the surrounding game logic, slave = the sequencer.
// ---------------------------------------------------------------------------
interface game_ctrl_if
  import game_pkg::*;
#(
  parameter int SCORE_W = 8
) ();

  logic               frame_tick;
  logic               start_btn;
  logic               collision;
  logic               food_eaten;
  logic               move_en;
  logic               game_over;
  color_mode_t        color_mode;
  logic [SCORE_W-1:0] score;

  modport master (
    output frame_tick, start_btn, collision, food_eaten,
    input  move_en, game_over, color_mode, score
  );

  modport slave (
    input  frame_tick, start_btn, collision, food_eaten,
    output move_en, game_over, color_mode, score
  );

endinterface

// File: rtl/game_ctrl_frame_div.sv
// ---------------------------------------------------------------------------
// frame_div
// Programmable frame divider: counts frame ticks and emits a registered
// one-cycle moveEn after every div-th counted tick.
//   clk, rst_n : pixel clock, async active-low reset
//   clear      : synchronous restart of the count (wins over everything)
//   enable     : count ticks only while high
//   suppress   : a wrapping tick in this cycle produces no moveEn
//   frameTick  : frame pulse
//   div        : frames per move, already reflecting any change made this
//                cycle, so a shrinking divider clamps the count immediately
//   moveEn     : registered move strobe
// ---------------------------------------------------------------------------
module frame_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             suppress,
  input  logic             frameTick,
  input  logic [DIV_W-1:0] div,
  output logic             moveEn
);

  logic [DIV_W-1:0] frameCnt;
  logic             lastFrame;

  // Using >= rather than == keeps the counter safe if the divider has just
  // dropped below the current count in the same cycle as a tick.
  assign lastFrame = (frameCnt >= (div - DIV_W'(1)));

  // Frame counter and move strobe. moveEn defaults low every cycle so it can
  // never be wider than one clock. Without a tick, a count that no longer
  // fits under a reduced divider is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameCnt <= '0;
      moveEn   <= 1'b0;
    end else begin
      moveEn <= 1'b0;
      if (clear) begin
        frameCnt <= '0;
      end else if (enable && frameTick) begin
        if (lastFrame) begin
          frameCnt <= '0;
          moveEn   <= ~suppress;
        end else begin
          frameCnt <= frameCnt + DIV_W'(1);
        end
      end else if (frameCnt >= div) begin
        frameCnt <= '0;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
// Snake game sequencer: IDLE -> PLAY -> OVER_FLASH -> OVER_HOLD -> PLAY ...
// driven by frame ticks, start-button rising edges and collision/food pulses.
// All outputs are registered.
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : game_ctrl_if.slave (frame_tick, start_btn, collision, food_eaten
//           in; move_en, game_over, color_mode, score out)
// Parameters: MOVE_DIV starting frames/move, MIN_DIV fastest frames/move,
// SPEEDUP_EVERY foods per speed-up, FLASH_FRAMES flash length, FLASH_HALF
// frames per flash colour, SCORE_W score width.
// ---------------------------------------------------------------------------
module game_ctrl
  import game_pkg::*;
#(
  parameter int MOVE_DIV      = 8,
  parameter int MIN_DIV       = 2,
  parameter int SPEEDUP_EVERY = 4,
  parameter int FLASH_FRAMES  = 32,
  parameter int FLASH_HALF    = 8,
  parameter int SCORE_W       = 8
) (
  input logic       clk,
  input logic       rst_n,
  game_ctrl_if.slave bus
);

  localparam int DIV_W   = $clog2(MOVE_DIV + 1);
  localparam int FOOD_W  = $clog2(SPEEDUP_EVERY + 1);
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
  localparam int HALF_W  = $clog2(FLASH_HALF + 1);

  logic [1:0]         state;
  logic               startPrev;
  logic               startRise;
  logic               restart;
  logic               playing;
  logic               playFood;
  logic               lastFood;
  logic [DIV_W-1:0]   div;
  logic [DIV_W-1:0]   divNext;
  logic [FOOD_W-1:0]  foodCnt;
  logic [FLASH_W-1:0] flashCnt;
  logic [HALF_W-1:0]  halfCnt;
  logic [SCORE_W-1:0] score;
  logic               gameOver;
  color_mode_t        colorMode;
  logic               moveEn;

  // Start-button history resets high so a button held through reset has to
  // be released and pressed again before a game starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startPrev <= 1'b1;
    end else begin
      startPrev <= bus.start_btn;
    end
  end

  assign startRise = bus.start_btn & ~startPrev;
  assign restart   = startRise & ((state == ST_IDLE) | (state == ST_OVER_HOLD));
  assign playing   = (state == ST_PLAY);
  assign playFood  = playing & ~bus.collision & bus.food_eaten;
  assign lastFood  = (foodCnt == FOOD_W'(SPEEDUP_EVERY - 1));

  // Next divider value. Computed combinationally so the frame divider can
  // clamp its count in the same edge that the divider shrinks.
  always_comb begin
    divNext = div;
    if (restart) begin
      divNext = DIV_W'(MOVE_DIV);
    end else if (playFood && lastFood && (div > DIV_W'(MIN_DIV))) begin
      divNext = div - DIV_W'(1);
    end
  end

  frame_div #(
    .DIV_W (DIV_W)
  ) u_frameDiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (restart),
    .enable    (playing),
    .suppress  (bus.collision),
    .frameTick (bus.frame_tick),
    .div       (divNext),
    .moveEn    (moveEn)
  );

  // Sequencer FSM with score, speed-up and flash bookkeeping. A collision in
  // PLAY takes priority over food in the same cycle; start presses are only
  // honoured from IDLE and OVER_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div       <= DIV_W'(MOVE_DIV);
      foodCnt   <= '0;
      flashCnt  <= '0;
      halfCnt   <= '0;
      score     <= '0;
      gameOver  <= 1'b0;
      colorMode <= CM_NORMAL;
    end else begin
      div <= divNext;
      case (state)
        ST_IDLE, ST_OVER_HOLD: begin
          if (restart) begin
            state     <= ST_PLAY;
            score     <= '0;
            foodCnt   <= '0;
            gameOver  <= 1'b0;
            colorMode <= CM_NORMAL;
          end
        end
        ST_PLAY: begin
          if (bus.collision) begin
            state     <= ST_OVER_FLASH;
            flashCnt  <= '0;
            halfCnt   <= '0;
            gameOver  <= 1'b1;
            colorMode <= CM_RED;
          end else if (bus.food_eaten) begin
            if (score != {SCORE_W{1'b1}}) begin
              score <= score + SCORE_W'(1);
            end
            foodCnt <= lastFood ? '0 : foodCnt + FOOD_W'(1);
          end
        end
        ST_OVER_FLASH: begin
          if (bus.frame_tick) begin
            flashCnt <= flashCnt + FLASH_W'(1);
            if (halfCnt == HALF_W'(FLASH_HALF - 1)) begin
              halfCnt   <= '0;
              colorMode <= flashToggle(colorMode);
            end else begin
              halfCnt <= halfCnt + HALF_W'(1);
            end
            if (flashCnt == FLASH_W'(FLASH_FRAMES - 1)) begin
              state     <= ST_OVER_HOLD;
              colorMode <= CM_BLACK;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.move_en    = moveEn;
  assign bus.game_over  = gameOver;
  assign bus.color_mode = colorMode;
  assign bus.score      = score;

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl
// Directed bench for game_ctrl: a table of {inputs, expected outputs} rows
// applied one clock each, plus hand-written asynchronous reset sequences.
// ---------------------------------------------------------------------------
module tb_game_ctrl;
  import game_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  game_ctrl_if #(.SCORE_W(8)) bus ();

  game_ctrl #(
    .MOVE_DIV      (8),
    .MIN_DIV       (2),
    .SPEEDUP_EVERY (4),
    .FLASH_FRAMES  (32),
    .FLASH_HALF    (8),
    .SCORE_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       startBtn;
    logic       frameTick;
    logic       collision;
    logic       foodEaten;
    logic       expMove;
    logic       expOver;
    logic [1:0] expColor;
    logic [7:0] expScore;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  // Append one table row.
  task automatic addRow(input string name, input logic sb, input logic ft,
                        input logic col, input logic fe, input logic mv,
                        input logic go, input logic [1:0] cm, input int sc);
    vec_t v;
    v.name      = name;
    v.startBtn  = sb;
    v.frameTick = ft;
    v.collision = col;
    v.foodEaten = fe;
    v.expMove   = mv;
    v.expOver   = go;
    v.expColor  = cm;
    v.expScore  = 8'(sc);
    vecs.push_back(v);
  endtask

  task automatic checkOne(input string name, input string field,
                          input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h at %0t",
               name, field, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic mv, input logic go,
                             input logic [1:0] cm, input logic [7:0] sc);
    checkOne(name, "move_en", 8'(bus.move_en), 8'(mv));
    checkOne(name, "game_over", 8'(bus.game_over), 8'(go));
    checkOne(name, "color_mode", 8'(bus.color_mode), 8'(cm));
    checkOne(name, "score", bus.score, sc);
  endtask

  // Drive one cycle of inputs away from the active edge, then sample just
  // after the edge that registered them.
  task automatic applyStimulus(input logic sb, input logic ft,
                               input logic col, input logic fe);
    @(negedge clk);
    bus.start_btn  = sb;
    bus.frame_tick = ft;
    bus.collision  = col;
    bus.food_eaten = fe;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sc;
    logic [1:0] cm;

    bus.start_btn  = 1'b1;
    bus.frame_tick = 1'b0;
    bus.collision  = 1'b0;
    bus.food_eaten = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 1'b0, CM_NORMAL, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Button held through reset: ticks in IDLE never move the snake.
    sc = 0;
    for (int i = 1; i <= 8; i++) addRow("idleHeld", 1, 1, 0, 0, 0, 0, CM_NORMAL, 0);
    addRow("release", 0, 0, 0, 0, 0, 0, CM_NORMAL, 0);
    // Start press with a tick in the same cycle; that tick is not counted.
    addRow("startTick", 1, 1, 0, 0, 0, 0, CM_NORMAL, 0);
    for (int i = 1; i <= 24; i++) addRow("div8", 1, 1, 0, 0, (i % 8) == 0, 0, CM_NORMAL, 0);
    for (int i = 1; i <= 4; i++) begin sc++; addRow("food1", 1, 0, 0, 1, 0, 0, CM_NORMAL, sc); end
    for (int i = 1; i <= 7; i++) addRow("div7", 1, 1, 0, 0, i == 7, 0, CM_NORMAL, sc);
    for (int i = 1; i <= 4; i++) begin sc++; addRow("food2", 1, 0, 0, 1, 0, 0, CM_NORMAL, sc); end
    for (int i = 1; i <= 6; i++) addRow("div6", 1, 1, 0, 0, i == 6, 0, CM_NORMAL, sc);
    // Leave the count at 5, then shrink the divider to 5: count clamps to 0.
    for (int i = 1; i <= 5; i++) addRow("preClamp", 1, 1, 0, 0, 0, 0, CM_NORMAL, sc);
    for (int i = 1; i <= 4; i++) begin sc++; addRow("food3", 1, 0, 0, 1, 0, 0, CM_NORMAL, sc); end
    for (int i = 1; i <= 5; i++) addRow("div5", 1, 1, 0, 0, i == 5, 0, CM_NORMAL, sc);
    // 16 more foods: 5->4->3->2, then the floor holds at 2.
    for (int i = 1; i <= 16; i++) begin sc++; addRow("food4", 1, 0, 0, 1, 0, 0, CM_NORMAL, sc); end
    for (int i = 1; i <= 4; i++) addRow("div2", 1, 1, 0, 0, (i % 2) == 0, 0, CM_NORMAL, sc);
    // Score saturates at 255.
    for (int i = 1; i <= 230; i++) begin
      sc = (sc < 255) ? sc + 1 : 255;
      addRow("scoreSat", 1, 0, 0, 1, 0, 0, CM_NORMAL, sc);
    end
    addRow("tickBeforeCol", 1, 1, 0, 0, 0, 0, CM_NORMAL, sc);
    // Collision + food on a qualifying tick: no move, no score, flash starts red.
    addRow("colFoodTick", 1, 1, 1, 1, 0, 1, CM_RED, sc);
    addRow("flashRelease", 0, 0, 0, 0, 0, 1, CM_RED, sc);
    addRow("flashPress", 1, 0, 0, 0, 0, 1, CM_RED, sc);
    for (int i = 1; i <= 32; i++) begin
      if (i == 32) cm = CM_BLACK;
      else cm = (((i / 8) % 2) == 1) ? CM_BLACK : CM_RED;
      addRow("flash", 1, 1, i == 3, i == 1, 0, 1, cm, sc);
    end
    for (int i = 1; i <= 8; i++) addRow("hold", 1, 1, 0, 0, 0, 1, CM_BLACK, sc);
    addRow("holdRelease", 0, 0, 0, 0, 0, 1, CM_BLACK, sc);
    addRow("holdPress", 1, 0, 0, 0, 0, 0, CM_NORMAL, 0);
    for (int i = 1; i <= 8; i++) addRow("restartDiv8", 1, 1, 0, 0, i == 8, 0, CM_NORMAL, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].startBtn, vecs[i].frameTick, vecs[i].collision, vecs[i].foodEaten);
      checkOutput(vecs[i].name, vecs[i].expMove, vecs[i].expOver, vecs[i].expColor, vecs[i].expScore);
    end

    // Asynchronous reset mid-PLAY while move_en is high.
    applyStimulus(1, 0, 0, 1);
    checkOutput("rstFood", 0, 0, CM_NORMAL, 8'd1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 1, 0, 0);
      checkOutput("rstTicks", i == 8, 0, CM_NORMAL, 8'd1);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstPlay", 0, 0, CM_NORMAL, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 1, 0, 0);
      checkOutput("idleAfterRst", 0, 0, CM_NORMAL, 8'd0);
    end

    // Asynchronous reset during the flash phase.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("overBeforeRst", 0, 1, CM_RED, 8'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstFlash", 0, 0, CM_NORMAL, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, 0);
    checkOutput("idleAfterRst2", 0, 0, CM_NORMAL, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
